// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer. It drives one shared subtract bit-cell LSB first over WIDTH clocks.
// Optional feature: define SERIAL_SUB_FLAGS_EN to add a registered 'zero' result flag.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic             zero,
`endif
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             borrow_out_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero_q;
`endif

  logic             bit_a;
  logic             bit_b;
  logic             diff_bit;
  logic             borrow_d;
  logic [WIDTH-1:0] work_d;

  // The single subtract cell; each new result bit enters the working register from the MSB side.
  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    diff_bit = bit_a ^ bit_b ^ borrow_q;
    borrow_d = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    work_d   = (work_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      work_q       <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            work_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          work_q   <= work_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          // Results are published only on the last bit, so diff holds steady through a whole run.
          if (cnt_q == LastBit) begin
            diff_q       <= work_d;
            borrow_out_q <= borrow_d;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q       <= (work_d == '0);
`endif
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random bench for serial_sub_ctrl with one WIDTH=8 instance and one WIDTH=1 instance.
// The zero flag is checked only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       zero8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;
  logic       zero1;

  int nChecks;
  int nFails;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero       (zero8),
`endif
    .borrow_out (borrow8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero       (zero1),
`endif
    .borrow_out (borrow1)
  );

`ifndef SERIAL_SUB_FLAGS_EN
  assign zero8 = 1'b0;
  assign zero1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge with the given operands; returns at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    nChecks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ctl8: busy=%b done=%b want 0/0", busy8, done8); end
    nChecks++; if (diff8 !== 8'h00 || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_res8: diff=%h borrow=%b want 00/0", diff8, borrow8); end
    nChecks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || borrow1 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_w1: busy=%b done=%b diff=%b borrow=%b want 0", busy1, done1, diff1, borrow1); end
`ifdef SERIAL_SUB_FLAGS_EN
    nChecks++; if (zero8 !== 1'b0) begin nFails++; $display("[TB] FAIL reset_zero8: got %b want 0", zero8); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL idle_after_reset: busy=%b done=%b want 0/0", busy8, done8); end
  endtask

  task automatic test_basic;
    issue8(8'h5A, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      nChecks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_run cyc%0d: busy=%b done=%b want 1/0", i, busy8, done8); end
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done: done=%b busy=%b want 1/0", done8, busy8); end
    nChecks++; if (diff8 !== 8'h1E || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_result: diff=%h borrow=%b want 1e/0", diff8, borrow8); end
`ifdef SERIAL_SUB_FLAGS_EN
    nChecks++; if (zero8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_zero: got %b want 0", zero8); end
`endif
    @(negedge clk);
    nChecks++; if (done8 !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_pulse: done=%b want 0", done8); end
  endtask

  task automatic test_edges;
    issue8(8'h00, 8'h01);
    repeat (8) @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || diff8 !== 8'hFF || borrow8 !== 1'b1) begin nFails++; $display("[TB] FAIL underflow: done=%b diff=%h borrow=%b want 1/ff/1", done8, diff8, borrow8); end
`ifdef SERIAL_SUB_FLAGS_EN
    nChecks++; if (zero8 !== 1'b0) begin nFails++; $display("[TB] FAIL underflow_zero: got %b want 0", zero8); end
`endif
    issue8(8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    nChecks++; if (diff8 !== 8'hFF || borrow8 !== 1'b1) begin nFails++; $display("[TB] FAIL hold_midrun: diff=%h borrow=%b want ff/1", diff8, borrow8); end
    repeat (4) @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL equal_ops: done=%b diff=%h borrow=%b want 1/00/0", done8, diff8, borrow8); end
`ifdef SERIAL_SUB_FLAGS_EN
    nChecks++; if (zero8 !== 1'b1) begin nFails++; $display("[TB] FAIL equal_zero: got %b want 1", zero8); end
`endif
  endtask

  task automatic test_start_held;
    @(negedge clk);
    a8     = 8'h10;
    b8     = 8'h01;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'h00;
    nChecks++; if (busy8 !== 1'b1) begin nFails++; $display("[TB] FAIL held_accept: busy=%b want 1", busy8); end
    repeat (8) @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || diff8 !== 8'h0F || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL held_first: done=%b diff=%h borrow=%b want 1/0f/0", done8, diff8, borrow8); end
    @(negedge clk);
    nChecks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL held_early_accept: busy=%b done=%b want 0/0", busy8, done8); end
    @(negedge clk);
    start8 = 1'b0;
    nChecks++; if (busy8 !== 1'b1 || diff8 !== 8'h0F) begin nFails++; $display("[TB] FAIL held_reaccept: busy=%b diff=%h want 1/0f", busy8, diff8); end
    repeat (8) @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || diff8 !== 8'hFF || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL held_second: done=%b diff=%h borrow=%b want 1/ff/0", done8, diff8, borrow8); end
  endtask

  task automatic test_async_reset;
    issue8(8'h81, 8'h02);
    repeat (3) @(negedge clk);
    nChecks++; if (busy8 !== 1'b1 || diff8 !== 8'hFF) begin nFails++; $display("[TB] FAIL pre_reset: busy=%b diff=%h want 1/ff", busy8, diff8); end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin nFails++; $display("[TB] FAIL async_reset: busy=%b done=%b diff=%h borrow=%b want 0/0/00/0", busy8, done8, diff8, borrow8); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nChecks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_idle cyc%0d: done=%b busy=%b want 0/0", i, done8, busy8); end
    end
    issue8(8'h33, 8'h44);
    for (int i = 0; i < 8; i++) begin
      nChecks++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin nFails++; $display("[TB] FAIL post_reset_run cyc%0d: busy=%b done=%b want 1/0", i, busy8, done8); end
      if (i < 7) @(negedge clk);
    end
    @(negedge clk);
    nChecks++; if (done8 !== 1'b1 || diff8 !== 8'hEF || borrow8 !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_result: done=%b diff=%h borrow=%b want 1/ef/1", done8, diff8, borrow8); end
  endtask

  task automatic test_width1;
    logic [1:0] pair;
    logic       expDiff [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       expBorrow [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      pair   = p[1:0];
      a1     = pair[1];
      b1     = pair[0];
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      nChecks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin nFails++; $display("[TB] FAIL w1_run ab=%b: busy=%b done=%b want 1/0", pair, busy1, done1); end
      @(negedge clk);
      nChecks++; if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== expDiff[p] || borrow1 !== expBorrow[p]) begin nFails++; $display("[TB] FAIL w1_result ab=%b: done=%b busy=%b diff=%b borrow=%b want 1/0/%b/%b", pair, done1, busy1, diff1, borrow1, expDiff[p], expBorrow[p]); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] expDiff;
    logic       expBorrow;
    @(negedge clk);
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    start8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      ea = a8;
      eb = b8;
      @(negedge clk);
      start8 = 1'b0;
      expDiff   = ea - eb;
      expBorrow = (ea < eb);
      repeat (8) @(negedge clk);
      nChecks++; if (done8 !== 1'b1 || diff8 !== expDiff || borrow8 !== expBorrow) begin nFails++; $display("[TB] FAIL b2b #%0d %h-%h: done=%b diff=%h borrow=%b want 1/%h/%b", i, ea, eb, done8, diff8, borrow8, expDiff, expBorrow); end
      @(negedge clk);
      if (i < 199) begin
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        start8 = 1'b1;
      end
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    start8  = 1'b0;
    a8      = '0;
    b8      = '0;
    start1  = 1'b0;
    a1      = '0;
    b1      = '0;
    test_reset();
    test_basic();
    test_edges();
    test_start_held();
    test_async_reset();
    test_width1();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
